// File: rtl/hs_timeout_source.sv
// Valid/ready source that retries a held word after bounded waits,
// with a fixed backoff between attempts and a sticky error on exhaustion.
module hs_timeout_source #(
    parameter int DW       = 8,
    parameter int MAX_WAIT = 5,
    parameter int RETRIES  = 2,
    parameter int BACKOFF  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    input  logic          clr_err,
    output logic          done,
    output logic          timeout,
    output logic          err,
    output logic [2:0]    retry_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BACKOFF,
        ST_ERROR
    } state_t;

    localparam logic [3:0] W_LAST = 4'(MAX_WAIT - 1);
    localparam logic [3:0] B_LAST = 4'(BACKOFF - 1);
    localparam logic [2:0] R_MAX  = 3'(RETRIES);

    state_t     state;
    logic [3:0] wait_cnt;
    logic [3:0] bo_cnt;

    // Accept only when idle and out of reset.
    assign in_ready = rst && (state == ST_IDLE);

    // Attempt/backoff sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            err       <= 1'b0;
            retry_cnt <= '0;
            wait_cnt  <= '0;
            bo_cnt    <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        wait_cnt  <= '0;
                        retry_cnt <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (wait_cnt == W_LAST) begin
                        out_valid <= 1'b0;
                        timeout   <= 1'b1;
                        if (retry_cnt == R_MAX) begin
                            err   <= 1'b1;
                            state <= ST_ERROR;
                        end else begin
                            retry_cnt <= retry_cnt + 3'd1;
                            bo_cnt    <= '0;
                            state     <= ST_BACKOFF;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_BACKOFF: begin
                    if (bo_cnt == B_LAST) begin
                        out_valid <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ST_WAIT;
                    end else begin
                        bo_cnt <= bo_cnt + 4'd1;
                    end
                end
                ST_ERROR: begin
                    if (clr_err) begin
                        err   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_timeout_source.sv
// Directed bench for hs_timeout_source: transfers, retries,
// exhaustion, reset abort and stray ready during backoff.
module tb_hs_timeout_source;

    localparam int MW = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       clr_err;
    logic       done;
    logic       timeout;
    logic       err;
    logic [2:0] retry_cnt;

    int errors = 0;
    int checks = 0;

    hs_timeout_source #(
        .DW(8), .MAX_WAIT(MW), .RETRIES(2), .BACKOFF(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .clr_err(clr_err),
        .done(done),
        .timeout(timeout),
        .err(err),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor: data stable while valid, no early drop.
    initial begin
        int         vcnt;
        logic [7:0] pdata;
        logic       prdy;
        vcnt  = 0;
        pdata = '0;
        prdy  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                vcnt = 0;
                prdy = 1'b0;
            end else if (out_valid === 1'b1) begin
                if (vcnt > 0) chk("inv_stable", 32'(out_data), 32'(pdata));
                pdata = out_data;
                prdy  = out_ready;
                vcnt++;
            end else begin
                if (vcnt > 0)
                    chk("inv_drop", 32'(prdy || vcnt == MW), 1);
                vcnt = 0;
            end
        end
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tmo", 32'(timeout), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        chk("rst_inrdy", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("idle_inrdy", 32'(in_ready), 1);

        // Immediate ready
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("imm_valid", 32'(out_valid), 1);
        chk("imm_data", 32'(out_data), 32'h A5);
        chk("imm_inrdy", 32'(in_ready), 0);
        tick();
        chk("imm_drop", 32'(out_valid), 0);
        chk("imm_done", 32'(done), 1);
        chk("imm_tmo", 32'(timeout), 0);
        chk("imm_retry", 32'(retry_cnt), 0);
        chk("imm_inrdy2", 32'(in_ready), 1);
        out_ready = 1'b0;
        tick();
        chk("imm_done_off", 32'(done), 0);

        // Late ready on k=4
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_valid", 32'(out_valid), 1);
            chk("late_tmo", 32'(timeout), 0);
            tick();
        end
        chk("late_valid5", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("late_done", 32'(done), 1);
        chk("late_tmo2", 32'(timeout), 0);
        chk("late_drop", 32'(out_valid), 0);
        tick();

        // One retry
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < MW; i++) begin
            chk("r1_valid", 32'(out_valid), 1);
            chk("r1_data", 32'(out_data), 32'h A5);
            tick();
        end
        chk("r1_tmo", 32'(timeout), 1);
        chk("r1_bo0", 32'(out_valid), 0);
        chk("r1_retry", 32'(retry_cnt), 1);
        tick();
        chk("r1_tmo_off", 32'(timeout), 0);
        chk("r1_bo1", 32'(out_valid), 0);
        tick();
        chk("r1_rerise", 32'(out_valid), 1);
        chk("r1_data2", 32'(out_data), 32'h A5);
        tick();
        chk("r1_valid2", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("r1_done", 32'(done), 1);
        chk("r1_retry2", 32'(retry_cnt), 1);
        tick();

        // Exhaustion
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        for (int a = 0; a < 3; a++) begin
            for (int i = 0; i < MW; i++) begin
                chk("ex_valid", 32'(out_valid), 1);
                chk("ex_tmo_lo", 32'(timeout), 0);
                tick();
            end
            chk("ex_tmo", 32'(timeout), 1);
            chk("ex_retry", 32'(retry_cnt), (a < 2) ? a + 1 : 2);
            if (a < 2) begin
                tick();
                tick();
            end
        end
        chk("ex_err", 32'(err), 1);
        chk("ex_valid0", 32'(out_valid), 0);
        chk("ex_inrdy", 32'(in_ready), 0);
        tick();
        chk("ex_err_hold", 32'(err), 1);
        chk("ex_tmo_off", 32'(timeout), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err", 32'(err), 0);
        chk("clr_inrdy", 32'(in_ready), 1);
        chk("clr_retry", 32'(retry_cnt), 2);

        // Reset mid-WAIT
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mr_valid3", 32'(out_valid), 1);
        rst = 1'b0;
        tick();
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_retry", 32'(retry_cnt), 0);
        chk("mr_inrdy", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("mr_inrdy2", 32'(in_ready), 1);
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mr_data", 32'(out_data), 32'h 3C);
        chk("mr_valid2", 32'(out_valid), 1);
        tick();
        out_ready = 1'b0;
        chk("mr_done2", 32'(done), 1);
        tick();

        // Stray ready during backoff
        in_valid = 1'b1;
        in_data  = 8'h5E;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < MW; i++) tick();
        chk("st_tmo", 32'(timeout), 1);
        out_ready = 1'b1;
        tick();
        chk("st_bo_valid", 32'(out_valid), 0);
        chk("st_bo_done", 32'(done), 0);
        tick();
        out_ready = 1'b0;
        chk("st_done", 32'(done), 0);
        chk("st_rerise", 32'(out_valid), 1);
        for (int i = 0; i < MW; i++) begin
            chk("st_valid", 32'(out_valid), 1);
            tick();
        end
        chk("st_tmo2", 32'(timeout), 1);
        chk("st_retry", 32'(retry_cnt), 2);
        chk("st_done2", 32'(done), 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hs_timeout_source.md
Name: hs_timeout_source

Overview:
- Producer-side valid/ready source with retries. It sits directly upstream of a valid/ready consumer whose contract is: once rst is deasserted and valid rises, ready must arrive within 5 clock cycles.
- It takes one word from a local client, drives it on out_valid/out_data, and watches for out_ready inside a bounded window.
- If the window expires, it backs off and retries with the same data. After the retries are exhausted it enters a sticky error state.

Parameters:
- DW, 8, data width.
- MAX_WAIT, 5, number of out_valid-high cycles in which out_ready is accepted per attempt (legal range 1..16).
- RETRIES, 2, extra attempts after the first timeout (0..7).
- BACKOFF, 2, out_valid-low cycles between attempts (1..15).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- in_valid  input  1  client offers in_data.
- in_data  input  DW  client word.
- in_ready  output  1  block can accept a word.
- out_valid  output  1  word presented downstream.
- out_data  output  DW  presented word.
- out_ready  input  1  downstream accepts.
- clr_err  input  1  clears the sticky error.
- done  output  1  one-cycle pulse after a successful transfer.
- timeout  output  1  one-cycle pulse per expired attempt.
- err  output  1  sticky: all attempts failed.
- retry_cnt  output  3  retries used on the current or last word.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; out_valid=0, out_data=0, done=0, timeout=0, err=0, retry_cnt=0, internal wait counter=0.
  - in_ready=0 while rst==0.
  - Reset mid-operation aborts and drops the held word.
- in_ready is combinational: in_ready = rst && (state==IDLE).
- All other outputs are registered.
- States: IDLE, WAIT, BACKOFF, ERROR.
- IDLE:
  - On in_valid && in_ready: capture in_data into out_data, clear wait_cnt and retry_cnt.
  - Go to WAIT; out_valid=1 from the next cycle (call it cycle T).
- WAIT (out_valid=1, out_data held stable):
  - out_ready is sampled at the posedges ending cycles T..T+MAX_WAIT-1.
  - If out_ready=1 at posedge k (k ≤ MAX_WAIT-1): transfer completes. Next cycle out_valid=0, done=1 for one cycle, state=IDLE.
  - If out_ready=1 on the last allowed cycle, ready wins over timeout.
  - If the posedge ending cycle T+MAX_WAIT-1 sees out_ready=0: timeout=1 during cycle T+MAX_WAIT.
    - If retry_cnt==RETRIES: go to ERROR.
    - Otherwise: retry_cnt+1, go to BACKOFF.
- BACKOFF:
  - out_valid=0 for exactly BACKOFF cycles, then back to WAIT with wait_cnt=0 and the same out_data.
  - out_valid re-rises at cycle T+MAX_WAIT+BACKOFF.
  - out_ready is ignored.
- ERROR:
  - out_valid=0, err=1, in_ready=0; the word is dropped.
  - clr_err=1 at a posedge: err=0, state=IDLE, in_ready=1 from the next cycle.
  - retry_cnt keeps its final value until the next accept.
- out_ready while out_valid=0 is ignored (no done).
- clr_err outside ERROR is ignored.
- Throughput: at most one word per 2 cycles. in_ready is high in the cycle done pulses.
- wait_cnt never wraps; it saturates by construction at MAX_WAIT-1.
- retry_cnt never exceeds RETRIES.
- Protocol invariant (bench asserts it): while out_valid=1, out_data is stable and out_valid does not drop before an out_ready handshake or MAX_WAIT cycles, whichever comes first.

Test Plan (defaults MAX_WAIT=5, RETRIES=2, BACKOFF=2):
- Immediate ready: accept in_data=0xA5 with out_ready held 1.
  - out_valid high for 1 cycle with out_data=0xA5; done pulses next cycle.
  - timeout never asserts; retry_cnt=0.
- Late ready: out_ready first high on the 5th valid cycle (k=4).
  - Transfer succeeds, done=1, timeout=0, out_valid high exactly 5 cycles.
- One retry: out_ready low for attempt 1, high on the 2nd valid cycle of attempt 2.
  - One timeout pulse; out_valid low exactly 2 cycles.
  - retry_cnt=1; out_data stays 0xA5 throughout; done=1.
- Exhaustion: out_ready held 0.
  - 3 attempts of 5 valid cycles each; 3 timeout pulses.
  - Then err=1, out_valid=0, in_ready=0, retry_cnt=2.
  - clr_err pulse gives err=0 and in_ready=1 on the next cycle.
- Reset mid-WAIT: drive rst=0 on the 3rd valid cycle.
  - Next posedge: out_valid=0, done=0, retry_cnt=0, in_ready=0.
  - rst=1 gives in_ready=1; a new word 0x3C transfers normally.
- Stray ready: out_ready=1 only during BACKOFF cycles.
  - No done, no transfer; the attempt still times out on schedule.
